// File: rtl/id_stage_top_if.sv
// Decode-stage bus: IF/ID inputs, hazard sideband from EX/MEM, WB write port and ID/EX outputs.
// The master side drives the upstream inputs; the slave side is the decode stage itself.
interface id_stage_top_if #(
  parameter int DATA_W = 32
);
  logic [31:0]       if_id_pc;
  logic [31:0]       if_id_instruction;
  logic [3:0]        sr;
  logic              flush;
  logic              exe_wb_en;
  logic [3:0]        exe_dest;
  logic              exe_mem_r_en;
  logic              mem_wb_en;
  logic [3:0]        mem_dest;
  logic              wb_wb_en;
  logic [3:0]        wb_dest;
  logic [DATA_W-1:0] wb_value;
  logic              hazard_freeze;
  logic [31:0]       id_ex_pc;
  logic [DATA_W-1:0] id_ex_val_rn;
  logic [DATA_W-1:0] id_ex_val_rm;
  logic [3:0]        id_ex_dest;
  logic [3:0]        id_ex_src1;
  logic [3:0]        id_ex_src2;
  logic [3:0]        id_ex_exe_cmd;
  logic              id_ex_mem_r_en;
  logic              id_ex_mem_w_en;
  logic              id_ex_wb_en;
  logic              id_ex_b;
  logic              id_ex_s;
  logic              id_ex_imm;
  logic [11:0]       id_ex_shift_op;
  logic [23:0]       id_ex_simm24;

  modport master (
    output if_id_pc, if_id_instruction, sr, flush, exe_wb_en, exe_dest, exe_mem_r_en,
           mem_wb_en, mem_dest, wb_wb_en, wb_dest, wb_value,
    input  hazard_freeze, id_ex_pc, id_ex_val_rn, id_ex_val_rm, id_ex_dest, id_ex_src1,
           id_ex_src2, id_ex_exe_cmd, id_ex_mem_r_en, id_ex_mem_w_en, id_ex_wb_en, id_ex_b,
           id_ex_s, id_ex_imm, id_ex_shift_op, id_ex_simm24
  );

  modport slave (
    input  if_id_pc, if_id_instruction, sr, flush, exe_wb_en, exe_dest, exe_mem_r_en,
           mem_wb_en, mem_dest, wb_wb_en, wb_dest, wb_value,
    output hazard_freeze, id_ex_pc, id_ex_val_rn, id_ex_val_rm, id_ex_dest, id_ex_src1,
           id_ex_src2, id_ex_exe_cmd, id_ex_mem_r_en, id_ex_mem_w_en, id_ex_wb_en, id_ex_b,
           id_ex_s, id_ex_imm, id_ex_shift_op, id_ex_simm24
  );
endinterface

// File: rtl/id_stage_top.sv
// ARM-subset decode stage: register file, decoder, condition check, hazard detection, ID/EX register.
// Optional macro FORWARDING_EN: only a load in EX can stall; MEM-stage producers are forwarded downstream.
module id_stage_top #(
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic rst,
  id_stage_top_if.slave bus
);
  logic [3:0] cond, op, rn, rd, src2;
  logic [1:0] mode;
  logic       imm_bit, s_bit, is_str, two_src, use_src1, cond_pass, hazard;
  logic [3:0] cmd_d;
  logic       mem_r_d, mem_w_d, wb_d, b_d, s_d;
  logic [DATA_W-1:0] val_rn_d, val_rm_d;
  logic n_f, z_f, c_f, v_f;

  assign cond     = bus.if_id_instruction[31:28];
  assign mode     = bus.if_id_instruction[27:26];
  assign imm_bit  = bus.if_id_instruction[25];
  assign op       = bus.if_id_instruction[24:21];
  assign s_bit    = bus.if_id_instruction[20];
  assign rn       = bus.if_id_instruction[19:16];
  assign rd       = bus.if_id_instruction[15:12];
  assign is_str   = (mode == 2'b01) && !s_bit;
  assign src2     = is_str ? rd : bus.if_id_instruction[3:0];
  assign two_src  = !imm_bit || is_str;
  assign use_src1 = (mode != 2'b10);
  assign {n_f, z_f, c_f, v_f} = bus.sr;

  always_comb begin
    case (cond)
      4'h0:    cond_pass = z_f;
      4'h1:    cond_pass = !z_f;
      4'h2:    cond_pass = c_f;
      4'h3:    cond_pass = !c_f;
      4'h4:    cond_pass = n_f;
      4'h5:    cond_pass = !n_f;
      4'h6:    cond_pass = v_f;
      4'h7:    cond_pass = !v_f;
      4'h8:    cond_pass = c_f && !z_f;
      4'h9:    cond_pass = !c_f || z_f;
      4'hA:    cond_pass = (n_f == v_f);
      4'hB:    cond_pass = (n_f != v_f);
      4'hC:    cond_pass = !z_f && (n_f == v_f);
      4'hD:    cond_pass = z_f || (n_f != v_f);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Control decode; a failed condition turns the instruction into a no-op.
  always_comb begin
    cmd_d   = 4'b0000;
    mem_r_d = 1'b0;
    mem_w_d = 1'b0;
    wb_d    = 1'b0;
    b_d     = 1'b0;
    s_d     = 1'b0;
    case (mode)
      2'b00: begin
        wb_d = 1'b1;
        s_d  = s_bit;
        case (op)
          4'b1101: cmd_d = 4'b0001;
          4'b1111: cmd_d = 4'b1001;
          4'b0100: cmd_d = 4'b0010;
          4'b0101: cmd_d = 4'b0011;
          4'b0010: cmd_d = 4'b0100;
          4'b0110: cmd_d = 4'b0101;
          4'b0000: cmd_d = 4'b0110;
          4'b1100: cmd_d = 4'b0111;
          4'b0001: cmd_d = 4'b1000;
          4'b1010: begin cmd_d = 4'b0100; wb_d = 1'b0; end
          4'b1000: begin cmd_d = 4'b0110; wb_d = 1'b0; end
          default: begin wb_d = 1'b0; s_d = 1'b0; end
        endcase
      end
      2'b01: begin
        cmd_d   = 4'b0010;
        mem_r_d = s_bit;
        wb_d    = s_bit;
        mem_w_d = !s_bit;
      end
      2'b10:   b_d = 1'b1;
      default: ;
    endcase
    if (!cond_pass) begin
      cmd_d   = 4'b0000;
      mem_r_d = 1'b0;
      mem_w_d = 1'b0;
      wb_d    = 1'b0;
      b_d     = 1'b0;
      s_d     = 1'b0;
    end
  end

`ifdef FORWARDING_EN
  assign hazard = bus.exe_wb_en && bus.exe_mem_r_en &&
                  ((use_src1 && rn == bus.exe_dest) || (two_src && src2 == bus.exe_dest));
`else
  assign hazard = (bus.exe_wb_en && ((use_src1 && rn == bus.exe_dest) ||
                                     (two_src && src2 == bus.exe_dest))) ||
                  (bus.mem_wb_en && ((use_src1 && rn == bus.mem_dest) ||
                                     (two_src && src2 == bus.mem_dest)));
`endif
  assign bus.hazard_freeze = hazard;

  // r15 is not stored; it always reads as zero.
  logic [DATA_W-1:0] rf_q [15];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) rf_q[i] <= DATA_W'(i);
    end else if (bus.wb_wb_en && bus.wb_dest != 4'hF) begin
      rf_q[bus.wb_dest] <= bus.wb_value;
    end
  end

  // Write-through so an instruction decoded in the WB cycle sees the new value.
  always_comb begin
    val_rn_d = '0;
    val_rm_d = '0;
    if (rn != 4'hF)
      val_rn_d = (bus.wb_wb_en && bus.wb_dest == rn) ? bus.wb_value : rf_q[rn];
    if (src2 != 4'hF)
      val_rm_d = (bus.wb_wb_en && bus.wb_dest == src2) ? bus.wb_value : rf_q[src2];
  end

  logic [31:0]       pc_q;
  logic [DATA_W-1:0] val_rn_q, val_rm_q;
  logic [3:0]        dest_q, src1_q, src2_q, cmd_q;
  logic              mem_r_q, mem_w_q, wb_q, b_q, s_q, imm_q;
  logic [11:0]       shift_op_q;
  logic [23:0]       simm24_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0; val_rn_q <= '0; val_rm_q <= '0;
      dest_q <= '0; src1_q <= '0; src2_q <= '0; imm_q <= 1'b0;
      shift_op_q <= '0; simm24_q <= '0;
      cmd_q <= '0; mem_r_q <= 1'b0; mem_w_q <= 1'b0;
      wb_q <= 1'b0; b_q <= 1'b0; s_q <= 1'b0;
    end else begin
      pc_q       <= bus.if_id_pc;
      val_rn_q   <= val_rn_d;
      val_rm_q   <= val_rm_d;
      dest_q     <= rd;
      src1_q     <= rn;
      src2_q     <= src2;
      imm_q      <= imm_bit;
      shift_op_q <= bus.if_id_instruction[11:0];
      simm24_q   <= bus.if_id_instruction[23:0];
      if (bus.flush || hazard) begin
        cmd_q <= '0; mem_r_q <= 1'b0; mem_w_q <= 1'b0;
        wb_q <= 1'b0; b_q <= 1'b0; s_q <= 1'b0;
      end else begin
        cmd_q <= cmd_d; mem_r_q <= mem_r_d; mem_w_q <= mem_w_d;
        wb_q <= wb_d; b_q <= b_d; s_q <= s_d;
      end
    end
  end

  assign bus.id_ex_pc       = pc_q;
  assign bus.id_ex_val_rn   = val_rn_q;
  assign bus.id_ex_val_rm   = val_rm_q;
  assign bus.id_ex_dest     = dest_q;
  assign bus.id_ex_src1     = src1_q;
  assign bus.id_ex_src2     = src2_q;
  assign bus.id_ex_exe_cmd  = cmd_q;
  assign bus.id_ex_mem_r_en = mem_r_q;
  assign bus.id_ex_mem_w_en = mem_w_q;
  assign bus.id_ex_wb_en    = wb_q;
  assign bus.id_ex_b        = b_q;
  assign bus.id_ex_s        = s_q;
  assign bus.id_ex_imm      = imm_q;
  assign bus.id_ex_shift_op = shift_op_q;
  assign bus.id_ex_simm24   = simm24_q;
endmodule

// File: tb/tb_id_stage_top.sv
// Bench for id_stage_top: directed scenarios plus randomized traffic against an ISA-level model.
module tb_id_stage_top;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_stage_top_if #(.DATA_W(32)) bus ();
  id_stage_top #(.DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rn_v;
    logic [31:0] rm_v;
    logic [3:0]  dest, src1, src2, cmd;
    logic        mem_r, mem_w, wb, b, s, imm;
    logic [11:0] shop;
    logic [23:0] simm;
  } idex_t;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_regs [16];
  int op_cmd [16];

  function automatic idex_t observed();
    idex_t o;
    o.pc = bus.id_ex_pc; o.rn_v = bus.id_ex_val_rn; o.rm_v = bus.id_ex_val_rm;
    o.dest = bus.id_ex_dest; o.src1 = bus.id_ex_src1; o.src2 = bus.id_ex_src2;
    o.cmd = bus.id_ex_exe_cmd; o.mem_r = bus.id_ex_mem_r_en; o.mem_w = bus.id_ex_mem_w_en;
    o.wb = bus.id_ex_wb_en; o.b = bus.id_ex_b; o.s = bus.id_ex_s; o.imm = bus.id_ex_imm;
    o.shop = bus.id_ex_shift_op; o.simm = bus.id_ex_simm24;
    return o;
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] idx);
    if (idx == 4'hF) return 32'h0;
    if (bus.wb_wb_en && bus.wb_dest == idx) return bus.wb_value;
    return m_regs[idx];
  endfunction

  // ARM pairs: even code tests a predicate, the following odd code is its negation.
  function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    {n, z, cy, v} = f;
    if (c == 4'hE) return 1'b1;
    if (c == 4'hF) return 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic bit m_hazard();
    logic [31:0] ins;
    bit is_str, reads1, reads2;
    logic [3:0] rn, rm;
    ins = bus.if_id_instruction;
    is_str = (ins[27:26] == 2'b01) && !ins[20];
    reads1 = (ins[27:26] != 2'b10);
    reads2 = !ins[25] || is_str;
    rn = ins[19:16];
    rm = is_str ? ins[15:12] : ins[3:0];
`ifdef FORWARDING_EN
    return bus.exe_wb_en && bus.exe_mem_r_en &&
           ((reads1 && rn == bus.exe_dest) || (reads2 && rm == bus.exe_dest));
`else
    for (int p = 0; p < 2; p++) begin
      bit en;
      logic [3:0] d;
      en = (p == 0) ? bus.exe_wb_en : bus.mem_wb_en;
      d  = (p == 0) ? bus.exe_dest : bus.mem_dest;
      if (en && ((reads1 && rn == d) || (reads2 && rm == d))) return 1'b1;
    end
    return 1'b0;
`endif
  endfunction

  function automatic idex_t m_expect();
    idex_t e;
    logic [31:0] ins;
    bit is_str;
    ins = bus.if_id_instruction;
    is_str = (ins[27:26] == 2'b01) && !ins[20];
    e = '0;
    e.pc = bus.if_id_pc;
    e.dest = ins[15:12];
    e.src1 = ins[19:16];
    e.src2 = is_str ? ins[15:12] : ins[3:0];
    e.rn_v = m_read(e.src1);
    e.rm_v = m_read(e.src2);
    e.imm = ins[25];
    e.shop = ins[11:0];
    e.simm = ins[23:0];
    if (m_cond(ins[31:28], bus.sr) && !bus.flush && !m_hazard()) begin
      case (ins[27:26])
        2'b00: if (op_cmd[ins[24:21]] >= 0) begin
          e.cmd = 4'(op_cmd[ins[24:21]]);
          e.wb = !(ins[24:21] == 4'b1010 || ins[24:21] == 4'b1000);
          e.s = ins[20];
        end
        2'b01: begin
          e.cmd = 4'b0010;
          e.mem_r = ins[20];
          e.wb = ins[20];
          e.mem_w = !ins[20];
        end
        2'b10: e.b = 1'b1;
        default: ;
      endcase
    end
    return e;
  endfunction

  // Samples freeze/expectation at the negedge, then clocks and updates the model register file.
  task automatic advance(output idex_t exp, output bit frz_exp, output bit frz_obs);
    bit wr;
    logic [3:0] wd;
    logic [31:0] wv;
    @(negedge clk);
    exp = rst ? idex_t'('0) : m_expect();
    frz_exp = m_hazard();
    frz_obs = bus.hazard_freeze;
    wr = !rst && bus.wb_wb_en && bus.wb_dest != 4'hF;
    wd = bus.wb_dest;
    wv = bus.wb_value;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 15; i++) m_regs[i] = i;
    end else if (wr) begin
      m_regs[wd] = wv;
    end
    #1;
    $display("txn t=%0t rst=%0b instr=%08h sr=%h flush=%0b freeze=%0b wb=%0b cmd=%h", $time, rst,
             bus.if_id_instruction, bus.sr, bus.flush, frz_obs, bus.id_ex_wb_en, bus.id_ex_exe_cmd);
  endtask

  task automatic idle_inputs();
    bus.if_id_pc = 32'h0; bus.if_id_instruction = 32'h0; bus.sr = 4'h0; bus.flush = 1'b0;
    bus.exe_wb_en = 1'b0; bus.exe_dest = 4'h0; bus.exe_mem_r_en = 1'b0;
    bus.mem_wb_en = 1'b0; bus.mem_dest = 4'h0;
    bus.wb_wb_en = 1'b0; bus.wb_dest = 4'h0; bus.wb_value = 32'h0;
  endtask

  task automatic test_reset();
    idex_t e; bit fe, fo;
    rst = 1'b1;
    idle_inputs();
    bus.if_id_instruction = 32'hE3A0_1005;
    advance(e, fe, fo);
    advance(e, fe, fo);
    n_checks++;
    if (observed() !== idex_t'('0)) begin
      $display("FAIL reset_idex got=%h want=0", observed()); n_errors++;
    end
    n_checks++;
    if (fo !== 1'b0) begin
      $display("FAIL reset_freeze got=%0b want=0", fo); n_errors++;
    end
    rst = 1'b0;
    bus.if_id_instruction = 32'hE087_6009;  // ADD R6,R7,R9
    advance(e, fe, fo);
    n_checks++;
    if ({bus.id_ex_val_rn, bus.id_ex_val_rm} !== {32'd7, 32'd9}) begin
      $display("FAIL reset_regfile got=%h/%h want=7/9", bus.id_ex_val_rn, bus.id_ex_val_rm);
      n_errors++;
    end
  endtask

  task automatic test_mov();
    idex_t e; bit fe, fo;
    idle_inputs();
    bus.if_id_pc = 32'h0000_0004;
    bus.if_id_instruction = 32'hE3A0_1005;
    advance(e, fe, fo);
    n_checks++;
    if ({bus.id_ex_exe_cmd, bus.id_ex_wb_en, bus.id_ex_dest, bus.id_ex_imm, bus.id_ex_shift_op}
        !== {4'b0001, 1'b1, 4'd1, 1'b1, 12'h005}) begin
      $display("FAIL mov_fields got cmd=%h wb=%0b dest=%h imm=%0b sh=%h want 1/1/1/1/005",
               bus.id_ex_exe_cmd, bus.id_ex_wb_en, bus.id_ex_dest, bus.id_ex_imm, bus.id_ex_shift_op);
      n_errors++;
    end
    n_checks++;
    if (observed() !== e) begin
      $display("FAIL mov_model got=%h want=%h", observed(), e); n_errors++;
    end
  endtask

  task automatic test_hazard();
    idex_t e; bit fe, fo;
    bit want;
`ifdef FORWARDING_EN
    want = 1'b0;
`else
    want = 1'b1;
`endif
    idle_inputs();
    bus.if_id_instruction = 32'hE080_2001;  // ADD R2,R0,R1
    bus.exe_wb_en = 1'b1;
    bus.exe_dest = 4'd1;
    advance(e, fe, fo);
    n_checks++;
    if (fo !== want) begin
      $display("FAIL hazard_freeze got=%0b want=%0b", fo, want); n_errors++;
    end
    n_checks++;
    if ({bus.id_ex_wb_en, bus.id_ex_exe_cmd} !== {want ? 5'b0_0000 : 5'b1_0010}) begin
      $display("FAIL hazard_bubble got wb=%0b cmd=%h", bus.id_ex_wb_en, bus.id_ex_exe_cmd);
      n_errors++;
    end
    bus.exe_wb_en = 1'b0;
    advance(e, fe, fo);
    n_checks++;
    if ({fo, bus.id_ex_wb_en, bus.id_ex_exe_cmd} !== {1'b0, 1'b1, 4'b0010}) begin
      $display("FAIL hazard_clear got frz=%0b wb=%0b cmd=%h want 0/1/2", fo, bus.id_ex_wb_en,
               bus.id_ex_exe_cmd);
      n_errors++;
    end
  endtask

  task automatic test_bypass();
    idex_t e; bit fe, fo;
    idle_inputs();
    bus.if_id_instruction = 32'hE083_4005;  // ADD R4,R3,R5
    bus.wb_wb_en = 1'b1; bus.wb_dest = 4'd3; bus.wb_value = 32'hDEAD_BEEF;
    advance(e, fe, fo);
    n_checks++;
    if (bus.id_ex_val_rn !== 32'hDEAD_BEEF) begin
      $display("FAIL bypass_rn got=%h want=deadbeef", bus.id_ex_val_rn); n_errors++;
    end
    bus.wb_wb_en = 1'b0;
    advance(e, fe, fo);
    n_checks++;
    if (bus.id_ex_val_rn !== 32'hDEAD_BEEF) begin
      $display("FAIL regfile_hold got=%h want=deadbeef", bus.id_ex_val_rn); n_errors++;
    end
    bus.if_id_instruction = 32'hE08F_400F;  // r15 reads zero, and r15 writes are dropped
    bus.wb_wb_en = 1'b1; bus.wb_dest = 4'hF; bus.wb_value = 32'h1234_5678;
    advance(e, fe, fo);
    n_checks++;
    if ({bus.id_ex_val_rn, bus.id_ex_val_rm} !== 64'h0) begin
      $display("FAIL r15_zero got=%h/%h want=0/0", bus.id_ex_val_rn, bus.id_ex_val_rm);
      n_errors++;
    end
  endtask

  task automatic test_cond();
    idex_t e; bit fe, fo;
    idle_inputs();
    bus.if_id_instruction = 32'h0083_4005;  // ADDEQ
    bus.sr = 4'b0000;
    advance(e, fe, fo);
    n_checks++;
    if ({bus.id_ex_wb_en, bus.id_ex_exe_cmd, bus.id_ex_mem_r_en, bus.id_ex_mem_w_en, bus.id_ex_b,
         bus.id_ex_s} !== 9'h0) begin
      $display("FAIL cond_fail got wb=%0b cmd=%h want 0/0", bus.id_ex_wb_en, bus.id_ex_exe_cmd);
      n_errors++;
    end
    bus.sr = 4'b0100;
    advance(e, fe, fo);
    n_checks++;
    if ({bus.id_ex_wb_en, bus.id_ex_exe_cmd} !== 5'b1_0010) begin
      $display("FAIL cond_pass got wb=%0b cmd=%h want 1/2", bus.id_ex_wb_en, bus.id_ex_exe_cmd);
      n_errors++;
    end
  endtask

  task automatic test_flush();
    idex_t e; bit fe, fo;
    idle_inputs();
    bus.if_id_instruction = 32'hE080_2001;
    bus.flush = 1'b1;
    bus.exe_wb_en = 1'b1; bus.exe_dest = 4'd1; bus.exe_mem_r_en = 1'b1;
    advance(e, fe, fo);
    n_checks++;
    if ({bus.id_ex_wb_en, bus.id_ex_exe_cmd} !== 5'h0) begin
      $display("FAIL flush_ctrl got wb=%0b cmd=%h want 0/0", bus.id_ex_wb_en, bus.id_ex_exe_cmd);
      n_errors++;
    end
    bus.flush = 1'b0; bus.exe_wb_en = 1'b0; bus.exe_mem_r_en = 1'b0;
    advance(e, fe, fo);
    n_checks++;
    if ({bus.id_ex_wb_en, bus.id_ex_exe_cmd} !== 5'b1_0010) begin
      $display("FAIL flush_no_bubble got wb=%0b cmd=%h want 1/2", bus.id_ex_wb_en,
               bus.id_ex_exe_cmd);
      n_errors++;
    end
  endtask

  task automatic test_forwarding();
    idex_t e; bit fe, fo;
    bit want_mem;
`ifdef FORWARDING_EN
    want_mem = 1'b0;
`else
    want_mem = 1'b1;
`endif
    idle_inputs();
    bus.if_id_instruction = 32'hE080_2001;
    bus.mem_wb_en = 1'b1; bus.mem_dest = 4'd0;
    advance(e, fe, fo);
    n_checks++;
    if (fo !== want_mem) begin
      $display("FAIL fwd_mem_match got=%0b want=%0b", fo, want_mem); n_errors++;
    end
    bus.mem_wb_en = 1'b0;
    bus.exe_wb_en = 1'b1; bus.exe_mem_r_en = 1'b1; bus.exe_dest = 4'd1;
    advance(e, fe, fo);
    n_checks++;
    if (fo !== 1'b1) begin
      $display("FAIL fwd_load_use got=%0b want=1", fo); n_errors++;
    end
  endtask

  task automatic test_reset_mid_stall();
    idex_t e; bit fe, fo;
    idle_inputs();
    bus.if_id_instruction = 32'hE080_2001;
    bus.exe_wb_en = 1'b1; bus.exe_mem_r_en = 1'b1; bus.exe_dest = 4'd1;
    rst = 1'b1;
    advance(e, fe, fo);
    n_checks++;
    if (observed() !== idex_t'('0)) begin
      $display("FAIL reset_mid_stall got=%h want=0", observed()); n_errors++;
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    idex_t e; bit fe, fo;
    logic [31:0] ins;
    for (int i = 0; i < 80; i++) begin
      ins = $urandom;
      if ($urandom_range(0, 3) != 0) ins[31:28] = 4'hE;
      if ($urandom_range(0, 3) != 0) ins[27:26] = 2'($urandom_range(0, 2));
      bus.if_id_pc = $urandom;
      bus.if_id_instruction = ins;
      bus.sr = 4'($urandom);
      bus.flush = ($urandom_range(0, 9) == 0);
      bus.exe_wb_en = ($urandom_range(0, 2) == 0);
      bus.exe_dest = 4'($urandom);
      bus.exe_mem_r_en = $urandom_range(0, 1) == 1;
      bus.mem_wb_en = ($urandom_range(0, 2) == 0);
      bus.mem_dest = 4'($urandom);
      bus.wb_wb_en = $urandom_range(0, 1) == 1;
      bus.wb_dest = 4'($urandom);
      bus.wb_value = $urandom;
      advance(e, fe, fo);
      n_checks++;
      if (fo !== fe) begin
        $display("FAIL rand_freeze[%0d] got=%0b want=%0b", i, fo, fe); n_errors++;
      end
      n_checks++;
      if (observed() !== e) begin
        $display("FAIL rand_idex[%0d] instr=%h got=%h want=%h", i, ins, observed(), e);
        n_errors++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) op_cmd[i] = -1;
    op_cmd[4'b1101] = 1; op_cmd[4'b1111] = 9; op_cmd[4'b0100] = 2; op_cmd[4'b0101] = 3;
    op_cmd[4'b0010] = 4; op_cmd[4'b0110] = 5; op_cmd[4'b0000] = 6; op_cmd[4'b1100] = 7;
    op_cmd[4'b0001] = 8; op_cmd[4'b1010] = 4; op_cmd[4'b1000] = 6;
    for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
    test_reset();
    test_mov();
    test_hazard();
    test_bypass();
    test_cond();
    test_flush();
    test_forwarding();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
